div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider for the five-stage core. It serves DIV/DIVU from the execute stage: ex issues operands and a start request, holds them while the divider iterates, and takes back a 64-bit {remainder, quotient} for the HI/LO path. It uses one quotient bit per cycle, restoring division, with signed/unsigned support, a divide-by-zero short path and annul for flushes.

## Interface
- No parameters; data width is fixed at 32 bits, result at 64 bits.
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
- opdata1_i  in  32  dividend; sampled with start_i
- opdata2_i  in  32  divisor; sampled with start_i
- start_i  in  1  request; held high by ex until ready_o seen
- annul_i  in  1  abort current operation (pipeline flush)
- result_o  out  64  [63:32] remainder, [31:0] quotient
- ready_o  out  1  result_o valid

## Operation
- States are FREE, BYZERO, ON and END. Reset forces FREE, cnt=0, result_o=0, ready_o=0.
- FREE
  - start_i=1 and annul_i=0 with divisor=0: go to BYZERO.
  - start_i=1 and annul_i=0 with divisor≠0: go to ON.
  - Signed mode latches |dividend| and |divisor|, plus both sign bits.
  - Unsigned mode latches the raw values.
  - Load 65-bit work reg = {32'b0, dividend_abs, 1'b0}; cnt=0.
  - Otherwise stay; ready_o=0, result_o=0.
- BYZERO: annul_i=1 goes to FREE. Else go to END with work quotient/remainder = 0.
- ON, per edge with annul_i=0 and cnt<32:
  - diff = {1'b0, work[63:32]} − {1'b0, divisor_abs} (33 bits).
  - diff[32]=1: work = work<<1.
  - diff[32]=0: work = {diff[31:0], work[31:0], 1'b1}.
  - cnt++.
- ON, cnt==32: go to END.
  - Quotient is work[31:0] and remainder is work[64:33].
  - Signed correction:
    - quotient is negated when the sign bits differ;
    - remainder is negated when the dividend was negative.
  - Register the result into result_o and set ready_o=1.
- ON, annul_i=1: go to FREE; ready_o=0, result_o=0; the partial result is discarded.
- END:
  - Hold result_o/ready_o while start_i=1.
  - start_i=0 goes to FREE and clears ready_o and result_o on the same edge.
  - annul_i is ignored in END.
- Operand changes after the sampling edge have no effect.
- start_i in ON/BYZERO has no effect other than being required to remain high; ex guarantees this.
- Arithmetic is modulo 2^32.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0; no trap.
  - The abs of 0x80000000 is 0x80000000 treated as unsigned.

## Timing
- Edges are numbered from E0, the edge sampling start_i=1 in FREE.
- Normal path: E1..E32 perform iterations 1..32. E33 enters END; ready_o=1 from after E33, for a latency of 33 cycles.
- Divide by zero: E1 enters BYZERO→END transition; ready_o=1 from after E1, result 0.
- ready_o and result_o are registered outputs with no combinational path from inputs.
- Back-to-back operations:
  - after ready_o, start_i must drop for at least one edge (END→FREE);
  - the next start is sampled on the following edge, at the earliest.
- Async reset at any point, including mid-ON or in END: outputs 0 immediately, state FREE, no pending result survives.

## Test plan
- Unsigned 100 / 7 (signed_div_i=0), start held: ready_o rises after E33; result_o = 0x00000002_0000000E. Drop start: ready_o=0 and result_o=0 one edge later.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002): result_o = 0xFFFFFFFF_FFFFFFFD. Also unsigned 0xFFFFFFF9 / 2: result_o = 0x00000001_7FFFFFFC.
- Divide by zero: 1234 / 0, signed and unsigned. ready_o after E1, result_o = 0; no ON cycles.
- Annul mid-operation:
  - Start 1000 / 3, assert annul_i for one cycle at E10: FREE, ready_o never rises.
  - Then start 1000 / 3: result_o = 0x00000001_0000014D after 33 edges.
- Overflow and extreme operands:
  - Signed 0x80000000 / 0xFFFFFFFF gives 0x00000000_80000000.
  - Unsigned 0xFFFFFFFF / 0xFFFFFFFF gives 0x00000000_00000001.
- Async reset:
  - Assert rst between edges at E20: ready_o/result_o are 0 before the next edge.
  - After release, a new 50 / 5 gives 0x00000000_0000000A with normal latency.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider (one quotient bit per cycle), signed/unsigned,
// divide-by-zero short path and flush annul; result is {remainder, quotient}.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);
  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;
  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs, q_fix, r_fix;
  logic [32:0] diff;
  assign a_neg = signed_div_i & opdata1_i[31];
  assign b_neg = signed_div_i & opdata2_i[31];
  assign a_abs = a_neg ? -opdata1_i : opdata1_i;
  assign b_abs = b_neg ? -opdata2_i : opdata2_i;
  assign diff  = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
  // Quotient takes the xor of the operand signs; remainder follows the dividend.
  assign q_fix = (sa_q ^ sb_q) ? -work_q[31:0] : work_q[31:0];
  assign r_fix = sa_q ? -work_q[64:33] : work_q[64:33];
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      S_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          state_d   = (opdata2_i == '0) ? S_BYZERO : S_ON;
          divisor_d = b_abs;
          sa_d      = a_neg;
          sb_d      = b_neg;
          work_d    = {32'b0, a_abs, 1'b0};
          cnt_d     = '0;
        end
      end
      S_BYZERO: begin
        if (annul_i) state_d = S_FREE;
        else begin
          state_d  = S_END;
          work_d   = '0;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != 6'd32) begin
          work_d = diff[32] ? {work_q[63:0], 1'b0} : {diff[31:0], work_q[31:0], 1'b1};
          cnt_d  = cnt_q + 6'd1;
        end else begin
          state_d  = S_END;
          result_d = {r_fix, q_fix};
          ready_d  = 1'b1;
        end
      end
      default: begin
        if (!start_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end
  assign result_o = result_q;
  assign ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table vectors, corner sequences and random ops against an arithmetic reference model.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = '0, op2 = '0;
  logic        start = 1'b0, annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  int          n_vec = 0, n_err = 0;

  div_unit dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 64'h00000000_80000000;
    sa = a;
    sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  task automatic do_op(input string nm, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    int lat;
    @(negedge clk);
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk); #1;
    op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom);
    lat = 0;
    while (!ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), (b == 0) ? 64'd1 : 64'd33);
    chk({nm, " result"}, result, exp);
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    chk({nm, " hold in END"}, {result[62:0], ready}, {exp[62:0], 1'b1});
    start = 1'b0;
    @(posedge clk); #1;
    chk({nm, " clear"}, {result[62:0], ready}, 64'd0);
  endtask

  initial begin
    logic        sgn;
    logic [31:0] a, b;
    bit          seen;
    tbl[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E};
    tbl[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD};
    tbl[2] = '{1'b0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC};
    tbl[3] = '{1'b1, 32'd1234,       32'd0,        64'd0};
    tbl[4] = '{1'b0, 32'd1234,       32'd0,        64'd0};
    tbl[5] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000};
    tbl[6] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'h00000000_00000001};
    tbl[7] = '{1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
    #1;
    chk("reset state", {result[62:0], ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) do_op($sformatf("tbl%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].exp);

    // annul mid-operation: start dropped together with annul so FREE does not restart
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; seen |= ready; end
    chk("annul no ready", 64'(seen), 64'd0);
    do_op("after annul", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D);

    // async reset mid-ON
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; end
    #2 rst = 1'b1; start = 1'b0;
    #1 chk("reset mid-ON", {result[62:0], ready}, 64'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; seen |= ready; end
    chk("no result after reset", 64'(seen), 64'd0);
    do_op("post-reset 50/5", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A);

    // async reset while holding a result in END
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    for (int i = 0; i < 35; i++) begin @(posedge clk); #1; end
    chk("END before reset", {result[62:0], ready}, {64'h00000002_0000000E, 1'b1});
    #2 rst = 1'b1;
    #1 chk("reset in END", {result[62:0], ready}, 64'd0);
    start = 1'b0;
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'hFFFFFFFF;
        3: b = 32'h80000000;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (i % 7 == 3) a = 32'h80000000;
      do_op($sformatf("rand%0d %h/%h s%0d", i, a, b, sgn), sgn, a, b, model(sgn, a, b));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
